// File: rtl/trace_capture.sv
// trace_capture: records processor register-write events in a circular buffer,
// freezes it a programmable number of events after a PC trigger, then drains it.
module trace_capture #(
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] prog_count,
    input  logic [5:0]           instr_opcode,
    input  logic [4:0]           write_reg_addr,
    input  logic [WORD_SIZE-1:0] write_reg_data,
    input  logic                 reg_write,
    input  logic                 arm,
    input  logic [WORD_SIZE-1:0] trig_pc,
    input  logic [ADDR_W:0]      post_count,
    input  logic                 rd_req,
    output logic [1:0]           state,
    output logic [ADDR_W:0]      entry_count,
    output logic                 overflow,
    output logic                 rd_valid,
    output logic [WORD_SIZE-1:0] rd_pc,
    output logic [5:0]           rd_opcode,
    output logic [4:0]           rd_waddr,
    output logic [WORD_SIZE-1:0] rd_wdata
);
    localparam int EW = 2*WORD_SIZE+11;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PONE = ADDR_W'(1);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
    state_t st;
    logic [ADDR_W-1:0] wptr, rptr;
    logic [ADDR_W:0] remain, clamp, rw_w;
    logic [EW-1:0] mem [DEPTH];
    logic trig, rec;
    assign clamp = post_count > FULL ? FULL : post_count;
    assign rw_w = (ADDR_W+1)'(reg_write);
    assign trig = !arm && st == ARMED && prog_count == trig_pc;
    // A trigger with a zero post count freezes before its own event lands.
    assign rec = !arm && reg_write && (st == CAPTURE || (st == ARMED && !(trig && clamp == '0)));
    assign state = st;
    always_ff @(posedge clk)
        if (rec) mem[wptr] <= {prog_count, instr_opcode, write_reg_addr, write_reg_data};
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            st <= IDLE;
            wptr <= '0;
            rptr <= '0;
            entry_count <= '0;
            overflow <= 1'b0;
            remain <= '0;
            rd_valid <= 1'b0;
            {rd_pc, rd_opcode, rd_waddr, rd_wdata} <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (arm) begin
                st <= ARMED;
                wptr <= '0;
                rptr <= '0;
                entry_count <= '0;
                overflow <= 1'b0;
                remain <= '0;
            end else begin
                if (rec) begin
                    wptr <= wptr + PONE;
                    if (entry_count == FULL) begin
                        rptr <= rptr + PONE;
                        overflow <= 1'b1;
                    end else entry_count <= entry_count + ONE;
                end
                if (trig) begin
                    remain <= clamp == '0 ? '0 : clamp - rw_w;
                    st <= (clamp == '0 || clamp == rw_w) ? DONE : CAPTURE;
                end
                if (st == CAPTURE && reg_write) begin
                    remain <= remain - ONE;
                    if (remain == ONE) st <= DONE;
                end
                if (st == DONE && rd_req && entry_count != '0) begin
                    rd_valid <= 1'b1;
                    {rd_pc, rd_opcode, rd_waddr, rd_wdata} <= mem[rptr];
                    rptr <= rptr + PONE;
                    entry_count <= entry_count - ONE;
                end
            end
        end
endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: queue-based reference model checked every cycle, plus directed literal checks.
module tb_trace_capture;
    localparam logic [31:0] IDLE_PC = 32'hDEAD_0000;
    logic clk = 0, rst = 1;
    logic [31:0] prog_count, write_reg_data, trig_pc;
    logic [5:0] instr_opcode;
    logic [4:0] write_reg_addr, post_count;
    logic reg_write, arm, rd_req;
    logic [1:0] state;
    logic [4:0] entry_count;
    logic overflow, rd_valid;
    logic [31:0] rd_pc, rd_wdata;
    logic [5:0] rd_opcode;
    logic [4:0] rd_waddr;

    trace_capture dut (
        .clk(clk), .rst(rst), .prog_count(prog_count), .instr_opcode(instr_opcode),
        .write_reg_addr(write_reg_addr), .write_reg_data(write_reg_data), .reg_write(reg_write),
        .arm(arm), .trig_pc(trig_pc), .post_count(post_count), .rd_req(rd_req),
        .state(state), .entry_count(entry_count), .overflow(overflow), .rd_valid(rd_valid),
        .rd_pc(rd_pc), .rd_opcode(rd_opcode), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    ent_t e_in;
    assign e_in = {prog_count, instr_opcode, write_reg_addr, write_reg_data};

    ent_t q[$];
    ent_t m_rd = '0;
    int m_state = 0, m_rem = 0, lim = 0;
    bit m_ovf = 0, m_rv = 0;
    int checks = 0, errors = 0;
    logic [31:0] popped[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void push(input ent_t e);
        q.push_back(e);
        if (q.size() > 16) begin
            void'(q.pop_front());
            m_ovf = 1;
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_state = 0; m_ovf = 0; m_rv = 0; m_rem = 0; m_rd = '0;
        end else begin
            m_rv = 0;
            if (arm) begin
                q.delete();
                m_ovf = 0; m_rem = 0; m_state = 1;
            end else if (m_state == 1) begin
                if (prog_count == trig_pc) begin
                    lim = post_count > 16 ? 16 : int'(post_count);
                    if (lim == 0) m_state = 3;
                    else begin
                        if (reg_write) push(e_in);
                        m_rem = lim - int'(reg_write);
                        m_state = m_rem == 0 ? 3 : 2;
                    end
                end else if (reg_write) push(e_in);
            end else if (m_state == 2) begin
                if (reg_write) begin
                    push(e_in);
                    m_rem--;
                    if (m_rem == 0) m_state = 3;
                end
            end else if (m_state == 3 && rd_req && q.size() > 0) begin
                m_rd = q.pop_front();
                m_rv = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("state", 64'(state), 64'(m_state));
        chk("entry_count", 64'(entry_count), 64'(q.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("rd_valid", 64'(rd_valid), 64'(m_rv));
        chk("rd_pc", 64'(rd_pc), 64'(m_rd.pc));
        chk("rd_fields", 64'({rd_opcode, rd_waddr, rd_wdata}), 64'({m_rd.op, m_rd.wa, m_rd.wd}));
        if (rd_valid) popped.push_back(rd_pc);
    end

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic ev(input logic [31:0] pc);
        prog_count = pc;
        instr_opcode = pc[7:2];
        write_reg_addr = pc[6:2];
        write_reg_data = {pc[15:0], ~pc[15:0]};
        reg_write = 1;
        @(negedge clk);
        reg_write = 0;
        prog_count = IDLE_PC;
    endtask

    task automatic rd();
        rd_req = 1;
        @(negedge clk);
        rd_req = 0;
    endtask

    task automatic arm_it(input logic [31:0] tpc, input logic [4:0] pcnt);
        trig_pc = tpc;
        post_count = pcnt;
        arm = 1;
        @(negedge clk);
        arm = 0;
    endtask

    logic [31:0] exp1 [5] = '{32'h04, 32'h08, 32'h10, 32'h14, 32'h18};

    initial begin
        prog_count = IDLE_PC; instr_opcode = 0; write_reg_addr = 0; write_reg_data = 0;
        reg_write = 0; arm = 0; trig_pc = 0; post_count = 0; rd_req = 0;
        #1 rst = 0;
        #20;
        @(negedge clk) rst = 1;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_count", 64'(entry_count), 64'd0);
        rd();
        // simple capture, with a read attempted during CAPTURE
        arm_it(32'h10, 5'd3);
        ev(32'h04); ev(32'h08); ev(32'h10);
        chk("cap_state", 64'(state), 64'd2);
        rd();
        ev(32'h14); ev(32'h18);
        chk("done_state", 64'(state), 64'd3);
        chk("done_count", 64'(entry_count), 64'd5);
        ev(32'h1C);
        chk("frozen_count", 64'(entry_count), 64'd5);
        popped.delete();
        repeat (6) rd();
        idle();
        chk("pop_num", 64'(popped.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            chk("pop_pc", 64'(i < popped.size() ? popped[i] : 32'hFFFF_FFFF), 64'(exp1[i]));
        // wrap with overflow
        arm_it(32'h200, 5'd1);
        for (int i = 0; i < 20; i++) ev(32'h100 + 32'(4*i));
        ev(32'h200);
        chk("wrap_state", 64'(state), 64'd3);
        chk("wrap_count", 64'(entry_count), 64'd16);
        chk("wrap_ovf", 64'(overflow), 64'd1);
        popped.delete();
        rd(); idle();
        chk("wrap_first", 64'(popped.size() > 0 ? popped[0] : 32'hFFFF_FFFF), 64'h114);
        // post_count 0
        arm_it(32'h300, 5'd0);
        ev(32'h280); ev(32'h284); ev(32'h300);
        chk("pc0_state", 64'(state), 64'd3);
        chk("pc0_count", 64'(entry_count), 64'd2);
        // post_count 31 clamps to 16
        arm_it(32'h400, 5'd31);
        ev(32'h380); ev(32'h384); ev(32'h388);
        ev(32'h400);
        for (int i = 1; i < 15; i++) ev(32'h400 + 32'(4*i));
        chk("clamp_mid_state", 64'(state), 64'd2);
        ev(32'h43C);
        chk("clamp_state", 64'(state), 64'd3);
        chk("clamp_count", 64'(entry_count), 64'd16);
        chk("clamp_ovf", 64'(overflow), 64'd1);
        ev(32'h4F0);
        chk("clamp_frozen", 64'(entry_count), 64'd16);
        popped.delete();
        rd(); idle();
        chk("clamp_first", 64'(popped.size() > 0 ? popped[0] : 32'hFFFF_FFFF), 64'h400);
        // arm beats rd_req
        trig_pc = 32'h600; post_count = 5'd2;
        arm = 1; rd_req = 1;
        @(negedge clk);
        arm = 0; rd_req = 0;
        chk("prio_state", 64'(state), 64'd1);
        chk("prio_count", 64'(entry_count), 64'd0);
        chk("prio_rv", 64'(rd_valid), 64'd0);
        chk("prio_ovf", 64'(overflow), 64'd0);
        // asynchronous reset mid-capture
        for (int i = 0; i < 17; i++) ev(32'h700 + 32'(4*i));
        ev(32'h600);
        chk("rst_pre_state", 64'(state), 64'd2);
        chk("rst_pre_ovf", 64'(overflow), 64'd1);
        @(posedge clk);
        #2 rst = 0;
        #1;
        chk("async_state", 64'(state), 64'd0);
        chk("async_count", 64'(entry_count), 64'd0);
        chk("async_ovf", 64'(overflow), 64'd0);
        chk("async_rv", 64'(rd_valid), 64'd0);
        @(negedge clk) rst = 1;
        rd(); idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/trace_capture.md
# trace_capture

Debug trace capture unit that consumes the single-cycle processor's debug outputs (program counter, opcode, write-back address and data). It records register-write events into a circular buffer, freezes the buffer a programmable number of events after a PC trigger, and lets a host drain the frozen trace over a request/valid read port. It sits beside the processor on the debug side of the datapath, and no processor signal depends on it.

## Interface
- WORD_SIZE, 32, width of the PC and write-back data
- DEPTH, 16, buffer entries; must be a power of two
- ADDR_W, 4, log2(DEPTH)
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  reset, asynchronous, active-low
- prog_count  in  WORD_SIZE  processor PC
- instr_opcode  in  6  current opcode
- write_reg_addr  in  5  write-back register address
- write_reg_data  in  WORD_SIZE  write-back data
- reg_write  in  1  write-back enable; qualifies an event
- arm  in  1  pulse; clears the buffer and starts a capture
- trig_pc  in  WORD_SIZE  PC value that fires the trigger
- post_count  in  ADDR_W+1  events to record after the trigger, clamped to DEPTH
- rd_req  in  1  pop request for the oldest entry
- state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
- entry_count  out  ADDR_W+1  valid entries, saturating at DEPTH
- overflow  out  1  sticky; set when an unread entry is overwritten
- rd_valid  out  1  one-cycle pulse; rd_* fields are valid
- rd_pc, rd_opcode, rd_waddr, rd_wdata  out  WORD_SIZE/6/5/WORD_SIZE  popped entry

## Operation
**Reset.** Reset (rst low) immediately forces:
- state IDLE;
- write pointer, read pointer and entry_count 0;
- overflow, rd_valid and all rd_* outputs 0;
- post-trigger counter 0.

Reset mid-capture discards the trace. Buffer RAM contents are don't-care.

**Event definition.** An event is any cycle with reg_write=1 in ARMED or CAPTURE. The entry stores {prog_count, instr_opcode, write_reg_addr, write_reg_data}.

**IDLE.** Nothing is recorded.
- arm -> ARMED.
- rd_req is ignored.

**ARMED.** Events are written at the write pointer, and the pointer wraps mod DEPTH.
- When entry_count==DEPTH, the new event overwrites the oldest entry. The read pointer advances with it, overflow is set, and entry_count stays at DEPTH.
- When prog_count==trig_pc, the post-trigger counter loads min(post_count, DEPTH). Then:
  - counter loaded with 0: the trigger-cycle event is NOT recorded, and state -> DONE.
  - otherwise: state -> CAPTURE, the trigger-cycle event (if any) is recorded, and it counts as the first post-trigger event.

**CAPTURE.** Each recorded event decrements the counter. The event that brings the counter to 0 is recorded, and state -> DONE on the same edge. Further trigger matches are ignored.

**DONE.** The buffer is frozen and no events are recorded. On rd_req with entry_count>0:
- the next cycle drives rd_valid=1 with the entry at the read pointer;
- the read pointer advances mod DEPTH;
- entry_count decrements.

rd_req with entry_count==0 is ignored (no rd_valid). The state remains DONE after the buffer is drained.

**arm from any state.** arm restarts the capture: pointers, entry_count, overflow and the counter are cleared, and state -> ARMED. arm has priority over rd_req, trigger and event recording in the same cycle. The cycle carrying arm records nothing and does not evaluate the trigger.

**Reads outside DONE.** rd_req in IDLE, ARMED or CAPTURE is ignored.

## Timing
- Inputs are sampled at posedge clk; all outputs are registered.
- A recorded event shows in entry_count one cycle after its sample edge.
- A state change is visible one cycle after its cause. Example: trigger sampled at edge N gives state==CAPTURE after edge N.
- Read latency is 1: rd_req sampled at edge N gives rd_valid high after edge N for exactly one cycle.
- Back-to-back rd_req is allowed and yields one entry per cycle, in oldest-first order.
- The host must not rely on rd_* data when rd_valid is low. rd_* fields hold their last popped value.
- overflow clears only on arm or reset.

## Test plan
- **Reset mid-CAPTURE:** drive rst low asynchronously mid-cycle -> state=0, entry_count=0, overflow=0 and rd_valid=0 before the next edge.
- **Simple capture:** arm; trig_pc=0x10, post_count=3; events at PCs 0x04, 0x08, 0x10, 0x14, 0x18, 0x1C -> DONE after the 0x18 event, entry_count=5. Six rd_req pulses return PCs 0x04, 0x08, 0x10, 0x14, 0x18, then no rd_valid on the sixth.
- **Wrap with overflow:** DEPTH=16; 20 pre-trigger events then trigger with post_count=1 -> entry_count=16, overflow=1, and the first pop returns the 6th pre-trigger event.
- **post_count=0:** trigger cycle has reg_write=1 -> DONE, entry_count excludes the trigger event, state==3 one cycle after the match.
- **post_count=31:** clamped to 16 -> exactly 16 post-trigger events, entry_count=16, overflow=1 if a pre-trigger history existed.
- **arm priority:** in DONE with entries, assert arm and rd_req together -> no rd_valid, state=ARMED, entry_count=0. rd_req during CAPTURE -> no rd_valid.
